sample_word_packer: RTL and testbench
=====================================

// Module: sample_word_packer
// PURPOSE
//  Parametrised, single-clock packer: SAMPLE_W-bit samples (or NARROW_W-bit in narrow mode) -> OUT_W-bit words, MSB-first, no gaps.
//  Successor to the fixed 18->64 pre-DDR assembler.
//  Adds: arbitrary widths; zero-padded flush of a partial word on capture end; valid/ready output with a 2-entry buffer; sticky overflow.
//  Sits between the capture front-end and the pre-DDR CDC FIFO.
// PARAMETERS
//  SAMPLE_W   18  full-mode sample width; 1 <= SAMPLE_W <= OUT_W
//  NARROW_W    8  narrow-mode sample width (i_data[NARROW_W-1:0]); 1 <= NARROW_W <= SAMPLE_W
//  OUT_W      64  output word width
//  OBUF_DEPTH  2  output buffer entries (power of 2, >= 2)
// PORTS
//  clk            in   1         clock
//  reset          in   1         asynchronous reset, active high
//  i_enable       in   1         0: state forced to IDLE, accumulator and buffer cleared
//  i_start        in   1         pulse: clears accumulator, samples i_narrow, enters RUN
//  i_narrow       in   1         mode select, sampled only on i_start
//  i_wr           in   1         sample strobe
//  i_data         in   SAMPLE_W  sample
//  i_done         in   1         pulse: capture finished, flush partial word
//  o_valid        out  1         output word valid
//  i_ready        in   1         downstream accepts when o_valid & i_ready
//  o_data         out  OUT_W     packed word; first sample in MSBs
//  o_last         out  1         qualifies o_data: final word of capture
//  o_done         out  1         1-cycle pulse: capture fully drained
//  o_overflow     out  1         sticky: word dropped, buffer full; cleared by i_start
//  o_word_count   out  32        words pushed since i_start (stats only)
//  o_drop_count   out  16        words dropped since i_start, saturating (stats only)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; accumulator, fill count and buffer empty.
//  Accumulator: ACC_W = OUT_W+SAMPLE_W bits; fill counter 0..ACC_W-1.
//   Accepted sample: acc <= {acc, s}; fill += w, where w = NARROW_W or SAMPLE_W.
//   If fill+w >= OUT_W: push acc[fill+w-1 -: OUT_W] into buffer same cycle; fill <= fill+w-OUT_W.
//  Latency: sample completing a word at edge t -> o_valid=1 after edge t (buffer was empty).
//  States:
//   IDLE  -i_start-> RUN.
//   RUN   -i_done-> FLUSH. A sample with i_wr=1 in the same cycle as i_done is packed first.
//   FLUSH: fill>0: push {acc[fill-1:0], zeros} with last=1. fill==0: mark the most recent buffered word last if still buffered, else push nothing.
//          Then -> DRAIN.
//   DRAIN -buffer empty-> DONE.
//   DONE  -> o_done=1 for one cycle -> IDLE.
//  Buffer: OBUF_DEPTH-entry FIFO, fall-through registered output, holds {last, data}.
//   Push while full: word dropped, o_overflow<=1, drop_count++. Accumulator continues unaffected.
//   Simultaneous pop and push while full: accepted, no overflow.
//  Precedence:
//   i_start over i_wr/i_done in any state: sample discarded, buffer flushed, overflow and stats cleared.
//   i_wr ignored in IDLE/FLUSH/DRAIN/DONE. i_done ignored outside RUN.
//   i_enable=0 overrides everything except reset.
//  Exact multiples (e.g. 32x18 = 9x64): no padding word; last word carries o_last.
// CONFIGURATION
//  PACKER_STATS_EN defined: o_word_count and o_drop_count are live registers.
//  Not defined: both tied to 0 and counter logic removed; port list unchanged.
// STRUCTURE
//  packer_pkg: state enum (IDLE, RUN, FLUSH, DRAIN, DONE); localparams ACC_W, FILL_W = $clog2(ACC_W), OBUF_AW.
//  Sub-module packer_obuf: OBUF_DEPTH x (OUT_W+1) sync FIFO with push/pop/full/empty.
//  Top level: accumulator, fill counter, FSM.
// TESTING
//  1 Full mode, ready=1: start, 32 samples 18'h00001..18'h00020, done.
//    -> 9 words; word0 = {18'h1,18'h2,18'h3,10'h000}; word8 o_last=1; o_done 1 cycle after drain.
//  2 Narrow: start with i_narrow=1, 8 samples 0x01..0x08.
//    -> one word 64'h0102030405060708.
//  3 Partial flush: full mode, 5 samples of 18'h3FFFF, done.
//    -> word0 = 64'hFFFF_FFFF_FFFF_FFFF; word1 = {26'h3FFFFFF, 38'h0} with o_last=1.
//  4 Backpressure: i_ready=0, 3 words produced.
//    -> 2 buffered, o_overflow=1, o_drop_count=1 (stats build).
//    Then ready=1 -> exactly 2 words out; i_start clears overflow.
//  5 i_start and i_wr in the same cycle.
//    -> sample discarded; next 4 samples produce the first word at fill boundary.
//  6 Async reset asserted mid-word, mid-cycle.
//    -> o_valid/o_done/o_overflow low immediately; no stale word after release.

Source files
------------

// File: rtl/packer_pkg.sv
// rtl/packer_pkg.sv - shared types and width helpers for the sample word packer
package packer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Accumulator must hold one full word plus the widest sample that overshoots it.
    function automatic int acc_width(int out_w, int sample_w);
        return out_w + sample_w;
    endfunction

    // Fill counter ranges 0..ACC_W-1.
    function automatic int fill_width(int acc_w);
        return $clog2(acc_w);
    endfunction

    // Output buffer pointer width; depth is a power of two >= 2.
    function automatic int obuf_aw(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/packer_obuf.sv
// rtl/packer_obuf.sv - small fall-through FIFO holding {last, data} output words
module packer_obuf
    import packer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             mark_last,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = obuf_aw(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only taken when a pop frees a slot the same cycle.
    assign do_push = push && (!full || do_pop);

    // Head word; a last-mark on the single buffered word shows up immediately.
    always_comb begin
        head = mem_q[rd_q];
        if (mark_last && (cnt_q == (AW+1)'(1))) begin
            head[WIDTH-1] = 1'b1;
        end
    end

    // Pointer, count and storage update.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (mark_last && !empty) begin
                mem_d[wr_q - 1'b1][WIDTH-1] = 1'b1;
            end
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_d = rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_word_packer.sv
// rtl/sample_word_packer.sv - packs samples MSB-first into output words; PACKER_STATS_EN enables counters
module sample_word_packer
    import packer_pkg::*;
#(
    parameter int SAMPLE_W   = 18,
    parameter int NARROW_W   = 8,
    parameter int OUT_W      = 64,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_narrow,
    input  logic                i_wr,
    input  logic [SAMPLE_W-1:0] i_data,
    input  logic                i_done,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [OUT_W-1:0]    o_data,
    output logic                o_last,
    output logic                o_done,
    output logic                o_overflow,
    output logic [31:0]         o_word_count,
    output logic [15:0]         o_drop_count
);

    localparam int ACC_W = acc_width(OUT_W, SAMPLE_W);
    localparam int FILL_W = fill_width(ACC_W);
    localparam int SUM_W = FILL_W + 1;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_shift;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               narrow_q, narrow_d;
    logic               overflow_q, overflow_d;
    logic [SUM_W-1:0]   w_len, fill_sum;
    logic [OUT_W-1:0]   pack_word, flush_word, push_word;
    logic               push, push_last, mark_last, obuf_clear;
    logic               pop, push_drop;
    logic               obuf_full, obuf_empty;
    logic [OUT_W:0]     obuf_head;

    // Shifted accumulator and candidate words for the current sample / flush.
    always_comb begin
        w_len     = narrow_q ? SUM_W'(NARROW_W) : SUM_W'(SAMPLE_W);
        fill_sum  = {1'b0, fill_q} + w_len;
        acc_shift = narrow_q ? {acc_q[ACC_W-NARROW_W-1:0], i_data[NARROW_W-1:0]}
                             : {acc_q[ACC_W-SAMPLE_W-1:0], i_data};
        pack_word  = OUT_W'(acc_shift >> (fill_sum - SUM_W'(OUT_W)));
        flush_word = OUT_W'(acc_q << (SUM_W'(OUT_W) - {1'b0, fill_q}));
    end

    // Accumulator, fill counter and buffer push control.
    always_comb begin
        acc_d      = acc_q;
        fill_d     = fill_q;
        narrow_d   = narrow_q;
        obuf_clear = 1'b0;
        push       = 1'b0;
        push_last  = 1'b0;
        push_word  = pack_word;
        mark_last  = 1'b0;
        if (!i_enable) begin
            acc_d      = '0;
            fill_d     = '0;
            obuf_clear = 1'b1;
        end else if (i_start) begin
            acc_d      = '0;
            fill_d     = '0;
            obuf_clear = 1'b1;
            narrow_d   = i_narrow;
        end else if (state_q == RUN && i_wr) begin
            acc_d = acc_shift;
            if (fill_sum >= SUM_W'(OUT_W)) begin
                push      = 1'b1;
                // A word completed exactly by the final sample is already the last one.
                push_last = i_done && (fill_sum == SUM_W'(OUT_W));
                fill_d    = FILL_W'(fill_sum - SUM_W'(OUT_W));
            end else begin
                fill_d = FILL_W'(fill_sum);
            end
        end else if (state_q == FLUSH) begin
            if (fill_q != '0) begin
                push      = 1'b1;
                push_last = 1'b1;
                push_word = flush_word;
            end else begin
                mark_last = 1'b1;
            end
            acc_d  = '0;
            fill_d = '0;
        end
    end

    assign pop       = o_valid && i_ready;
    assign push_drop = push && obuf_full && !pop;

    // Sticky overflow: set on any dropped word, cleared only by a new capture.
    always_comb begin
        overflow_d = overflow_q;
        if (i_enable && i_start) begin
            overflow_d = 1'b0;
        end else if (push_drop) begin
            overflow_d = 1'b1;
        end
    end

    // FSM next state; enable and start take priority over the capture flow.
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = IDLE;
        end else if (i_start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (i_done) state_d = FLUSH;
                FLUSH:   state_d = DRAIN;
                DRAIN:   if (obuf_empty) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        o_done = (state_q == DONE);
    end

    // State, accumulator and overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            fill_q     <= '0;
            narrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            narrow_q   <= narrow_d;
            overflow_q <= overflow_d;
        end
    end

    packer_obuf #(
        .DEPTH (OBUF_DEPTH),
        .WIDTH (OUT_W + 1)
    ) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .clear     (obuf_clear),
        .push      (push),
        .push_data ({push_last, push_word}),
        .pop       (pop),
        .mark_last (mark_last),
        .head      (obuf_head),
        .full      (obuf_full),
        .empty     (obuf_empty)
    );

    assign o_valid    = !obuf_empty;
    assign o_data     = obuf_head[OUT_W-1:0] & {OUT_W{o_valid}};
    assign o_last     = obuf_head[OUT_W] & o_valid;
    assign o_overflow = overflow_q;

`ifdef PACKER_STATS_EN
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        push_ok;

    assign push_ok = push && !push_drop;

    // Word and saturating drop counters, cleared by a new capture.
    always_comb begin
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (i_enable && i_start) begin
            word_cnt_d = '0;
            drop_cnt_d = '0;
        end else begin
            if (push_ok) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
            if (push_drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_word_count = word_cnt_q;
    assign o_drop_count = drop_cnt_q;
`else
    assign o_word_count = '0;
    assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_sample_word_packer.sv
// tb/tb_sample_word_packer.sv - self-checking bench for sample_word_packer
module tb_sample_word_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_start = 1'b0;
    logic        i_narrow = 1'b0;
    logic        i_wr = 1'b0;
    logic [17:0] i_data = '0;
    logic        i_done = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_valid, o_last, o_done, o_overflow;
    logic [63:0] o_data;
    logic [31:0] o_word_count;
    logic [15:0] o_drop_count;

`ifdef PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    sample_word_packer dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_start      (i_start),
        .i_narrow     (i_narrow),
        .i_wr         (i_wr),
        .i_data       (i_data),
        .i_done       (i_done),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_last       (o_last),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_word_count (o_word_count),
        .o_drop_count (o_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        last;
        logic [63:0] data;
    } word_t;

    typedef struct {
        bit          narrow;
        int          nsamp;
        logic [17:0] first;
        logic [17:0] step;
        bit          done_with_last;
        int          exp_words;
        logic [63:0] exp_w0;
        logic [63:0] exp_wlast;
    } vec_t;

    word_t sb[$];
    word_t rx_log[$];
    bit    bits[$];
    word_t mon_e;
    word_t mon_r;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bit stream of accepted samples, cut into 64-bit words.
    task automatic model_add(logic [17:0] s, bit narrow);
        int w;
        w = narrow ? 8 : 18;
        for (int i = w - 1; i >= 0; i--) bits.push_back(s[i]);
    endtask

    task automatic model_emit(bit fin);
        word_t e;
        while (bits.size() >= 64) begin
            for (int i = 63; i >= 0; i--) e.data[i] = bits.pop_front();
            e.last = 1'b0;
            sb.push_back(e);
        end
        if (fin) begin
            if (bits.size() > 0) begin
                e.data = '0;
                for (int i = 63; bits.size() > 0; i--) e.data[i] = bits.pop_front();
                e.last = 1'b1;
                sb.push_back(e);
            end else if (sb.size() > 0) begin
                sb[sb.size()-1].last = 1'b1;
            end
        end
    endtask

    // Output monitor: every accepted word is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && o_valid && i_ready) begin
            mon_r.data = o_data;
            mon_r.last = o_last;
            rx_log.push_back(mon_r);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %h expected none", o_data);
            end else begin
                mon_e = sb.pop_front();
                check("word_data", o_data, mon_e.data);
                check("word_last", {63'b0, o_last}, {63'b0, mon_e.last});
            end
        end
    end

    task automatic wait_done(int maxc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {63'b0, seen}, 64'd1);
        if (seen) begin
            check("drained_at_done", {63'b0, o_valid}, 64'd0);
            @(negedge clk);
            check("done_width", {63'b0, o_done}, 64'd0);
        end
    endtask

    task automatic do_start(bit narrow);
        i_start  = 1'b1;
        i_narrow = narrow;
        bits.delete();
        sb.delete();
        tick();
        i_start  = 1'b0;
        i_narrow = 1'b0;
    endtask

    task automatic run_vec(vec_t v);
        logic [17:0] s;
        rx_log.delete();
        i_ready = 1'b1;
        do_start(v.narrow);
        for (int k = 0; k < v.nsamp; k++) begin
            s      = v.first + v.step * 18'(k);
            i_wr   = 1'b1;
            i_data = s;
            model_add(s, v.narrow);
            if (k == v.nsamp - 1 && v.done_with_last) begin
                i_done = 1'b1;
                model_emit(1'b1);
            end else begin
                model_emit(1'b0);
            end
            tick();
        end
        i_wr   = 1'b0;
        i_data = '0;
        i_done = 1'b0;
        if (!v.done_with_last) begin
            i_done = 1'b1;
            model_emit(1'b1);
            tick();
            i_done = 1'b0;
        end
        wait_done(200);
        check("rx_count", 64'(rx_log.size()), 64'(v.exp_words));
        check("sb_empty", 64'(sb.size()), 64'd0);
        if (rx_log.size() > 0) begin
            check("first_word", rx_log[0].data, v.exp_w0);
            check("final_word", rx_log[rx_log.size()-1].data, v.exp_wlast);
            check("final_last", {63'b0, rx_log[rx_log.size()-1].last}, 64'd1);
        end
        check("word_count", {32'b0, o_word_count}, STATS ? 64'(v.exp_words) : 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int vcnt;
        logic [17:0] s;

        vecs[0] = '{1'b0, 32, 18'h00001, 18'h00001, 1'b1, 9,
                    {18'h1, 18'h2, 18'h3, 10'h000}, {10'h01D, 18'd30, 18'd31, 18'd32}};
        vecs[1] = '{1'b1, 8, 18'h00001, 18'h00001, 1'b1, 1,
                    64'h0102030405060708, 64'h0102030405060708};
        vecs[2] = '{1'b0, 5, 18'h3FFFF, 18'h00000, 1'b0, 2,
                    64'hFFFF_FFFF_FFFF_FFFF, {26'h3FFFFFF, 38'h0}};
        vecs[3] = '{1'b0, 7, 18'h2AAAA, 18'h01111, 1'b0, 2,
                    {18'h2AAAA, 18'h2BBBB, 18'h2CCCC, 10'h2DD},
                    {8'hDD, 18'h2EEEE, 18'h2FFFF, 18'h31110, 2'b00}};
        vecs[4] = '{1'b1, 13, 18'h3FFA5, 18'h00013, 1'b0, 2,
                    64'hA5B8CBDEF104172A, 64'h3D50637689000000};

        // Reset state.
        i_enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'b0, o_valid}, 64'd0);
        check("rst_last", {63'b0, o_last}, 64'd0);
        check("rst_done", {63'b0, o_done}, 64'd0);
        check("rst_overflow", {63'b0, o_overflow}, 64'd0);
        check("rst_data", o_data, 64'd0);
        check("rst_word_count", {32'b0, o_word_count}, 64'd0);
        check("rst_drop_count", {48'b0, o_drop_count}, 64'd0);
        reset = 1'b0;
        tick();

        // Table-driven captures with the consumer always ready.
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure: three words into a two-entry buffer.
        rx_log.delete();
        i_ready = 1'b0;
        do_start(1'b0);
        for (int k = 0; k < 11; k++) begin
            s      = 18'(k * 7919 + 18'h155);
            i_wr   = 1'b1;
            i_data = s;
            model_add(s, 1'b0);
            model_emit(1'b0);
            tick();
        end
        i_wr = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("bp_overflow", {63'b0, o_overflow}, 64'd1);
        check("bp_drop_count", {48'b0, o_drop_count}, STATS ? 64'd1 : 64'd0);
        check("bp_valid", {63'b0, o_valid}, 64'd1);
        i_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("bp_rx_count", 64'(rx_log.size()), 64'd2);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        do_start(1'b0);
        @(negedge clk);
        check("bp_overflow_cleared", {63'b0, o_overflow}, 64'd0);
        check("bp_drop_cleared", {48'b0, o_drop_count}, 64'd0);
        check("bp_valid_cleared", {63'b0, o_valid}, 64'd0);

        // Start together with a write: the sample is discarded.
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        rx_log.delete();
        i_ready  = 1'b0;
        i_start  = 1'b1;
        i_wr     = 1'b1;
        i_data   = 18'h15555;
        bits.delete();
        sb.delete();
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: s = 18'h12345;
                1: s = 18'h2468A;
                2: s = 18'h3579B;
                default: s = 18'h0ABCD;
            endcase
            i_wr   = 1'b1;
            i_data = s;
            model_add(s, 1'b0);
            model_emit(1'b0);
            tick();
            if (k == 2) begin
                @(negedge clk);
                check("sw_no_word_yet", {63'b0, o_valid}, 64'd0);
            end
        end
        i_wr = 1'b0;
        @(negedge clk);
        check("sw_word_valid", {63'b0, o_valid}, 64'd1);
        check("sw_word_data", o_data, {18'h12345, 18'h2468A, 18'h3579B, 10'h0AB});
        i_ready = 1'b1;
        i_done  = 1'b1;
        model_emit(1'b1);
        tick();
        i_done = 1'b0;
        wait_done(100);
        check("sw_rx_count", 64'(rx_log.size()), 64'd2);
        if (rx_log.size() == 2) check("sw_flush_word", rx_log[1].data, {8'hCD, 56'h0});

        // Asynchronous reset in the middle of a cycle with a word buffered.
        i_ready = 1'b0;
        do_start(1'b0);
        for (int k = 0; k < 5; k++) begin
            i_wr   = 1'b1;
            i_data = 18'(18'h0F0F0 + k);
            tick();
        end
        i_wr = 1'b0;
        @(negedge clk);
        check("ar_valid_before", {63'b0, o_valid}, 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid", {63'b0, o_valid}, 64'd0);
        check("ar_done", {63'b0, o_done}, 64'd0);
        check("ar_overflow", {63'b0, o_overflow}, 64'd0);
        sb.delete();
        bits.delete();
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_wr   = 1'b1;
            i_data = 18'(18'h3C3C3 + k);
            i_done = (k == 5);
            tick();
        end
        i_wr   = 1'b0;
        i_done = 1'b0;
        vcnt   = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_valid) vcnt++;
        end
        check("ar_no_stale", 64'(vcnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
